// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared display constants for the seven-segment scan driver/decoder pair.
// Glyphs are active-high with segment a on bit 0.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEG_W      = 7;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_W-1:0] GLYPH_ONE   = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_N     = 7'b1010100;
    localparam logic [SEG_W-1:0] GLYPH_P     = 7'b1110011;
    localparam logic [SEG_W-1:0] GLYPH_E     = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b0000000;

    typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_segs_t;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Scan-line inputs and rebuilt-frame outputs of the seven-segment scan decoder.
// master = scan driver / frame consumer side, slave = decoder.
interface seven_seg_scan_decoder_if;
    import seven_seg_pkg::*;

    logic [NUM_DIGITS-1:0]       AN_Scan;
    logic [SEG_W-1:0]            C_Scan;
    logic [NUM_DIGITS-1:0]       AN_Rx;
    logic [NUM_DIGITS*SEG_W-1:0] C_Rx;
    logic                        frame_valid;
    logic                        scan_err;

    modport master (
        output AN_Scan, C_Scan,
        input  AN_Rx, C_Rx, frame_valid, scan_err
    );

    modport slave (
        input  AN_Scan, C_Scan,
        output AN_Rx, C_Rx, frame_valid, scan_err
    );

endinterface

// File: rtl/seven_seg_scan_decoder_seg_onehot_index.sv
// Classifies an active-high anode vector as zero / one-hot / multi-hot and
// returns the selected digit index; purely combinational.
module seg_onehot_index
    import seven_seg_pkg::*;
(
    input  logic [NUM_DIGITS-1:0] an,
    output logic [IDX_W-1:0]      idx,
    output logic                  is_zero,
    output logic                  is_onehot,
    output logic                  is_multi
);

    localparam int ONES_W = $clog2(NUM_DIGITS + 1);

    logic [ONES_W-1:0] ones;

    always_comb begin
        idx  = '0;
        ones = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an[i]) begin
                idx  = IDX_W'(i);
                ones = ones + ONES_W'(1);
            end
        end
    end

    assign is_zero   = (ones == '0);
    assign is_onehot = (ones == ONES_W'(1));
    assign is_multi  = !is_zero && !is_onehot;

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Rebuilds the full display frame from multiplexed anode/cathode scan lines.
// One frame published per scan wrap or idle timeout; short glitches filtered, multi-hot anodes flagged.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int IDLE_MAX       = 1048576,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    seven_seg_scan_decoder_if.slave  bus
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int IDLE_W = $clog2(IDLE_MAX);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};

    logic [NUM_DIGITS-1:0] an_r, an_p, last_an;
    logic [SEG_W-1:0]      seg_r, seg_p, last_seg;
    logic [NUM_DIGITS-1:0] an_n;
    logic [SEG_W-1:0]      seg_n;
    logic [CNT_W-1:0]      cnt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [NUM_DIGITS-1:0] seen;
    frame_segs_t           shadow;
    logic [IDX_W-1:0]      last_idx;

    logic [IDX_W-1:0]      idx;
    logic                  is_zero, is_onehot, is_multi;
    logic                  same, commit, wrap, idle_hit;

    // XOR with the idle line level turns both polarities into active-high.
    assign an_n  = an_r ^ AN_OFF;
    assign seg_n = seg_r ^ SEG_OFF;

    seg_onehot_index u_idx (
        .an        (an_n),
        .idx       (idx),
        .is_zero   (is_zero),
        .is_onehot (is_onehot),
        .is_multi  (is_multi)
    );

    assign same = (an_n == an_p) && (seg_n == seg_p);
    // A glitch that returns to the already-committed sample must not re-commit
    // it, otherwise the repeated index would look like a scan wrap.
    assign commit   = same && (cnt == CNT_W'(STABLE_CYCLES - 2)) &&
                      ({an_n, seg_n} != {last_an, last_seg});
    assign wrap     = (seen != '0) && (idx <= last_idx);
    assign idle_hit = is_zero && (idle_cnt == IDLE_W'(IDLE_MAX - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            an_r            <= AN_OFF;
            seg_r           <= SEG_OFF;
            an_p            <= '0;
            seg_p           <= '0;
            last_an         <= '0;
            last_seg        <= '0;
            cnt             <= '0;
            idle_cnt        <= '0;
            seen            <= '0;
            shadow          <= '0;
            last_idx        <= '0;
            bus.AN_Rx       <= '0;
            bus.C_Rx        <= '0;
            bus.frame_valid <= 1'b0;
            bus.scan_err    <= 1'b0;
        end else begin
            an_r            <= bus.AN_Scan;
            seg_r           <= bus.C_Scan;
            an_p            <= an_n;
            seg_p           <= seg_n;
            bus.frame_valid <= 1'b0;
            bus.scan_err    <= 1'b0;

            if (!same)
                cnt <= '0;
            else if (cnt != CNT_W'(STABLE_CYCLES - 1))
                cnt <= cnt + CNT_W'(1);

            if (!is_zero)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_W'(IDLE_MAX - 1))
                idle_cnt <= idle_cnt + IDLE_W'(1);

            if (commit) begin
                last_an  <= an_n;
                last_seg <= seg_n;
            end

            if (commit && is_multi)
                bus.scan_err <= 1'b1;

            if (commit && is_onehot) begin
                last_idx <= idx;
                if (wrap) begin
                    bus.AN_Rx       <= seen;
                    bus.C_Rx        <= shadow;
                    bus.frame_valid <= 1'b1;
                    seen            <= '0;
                    shadow          <= '0;
                end
                seen[idx]   <= 1'b1;
                shadow[idx] <= seg_n;
            end

            // Idle timeout closes a frame whose tail digits are disabled.
            if (idle_hit) begin
                bus.AN_Rx       <= seen;
                bus.C_Rx        <= shadow;
                bus.frame_valid <= 1'b1;
                seen            <= '0;
                shadow          <= '0;
            end
        end
    end

endmodule
